ex_mul_div: RTL and testbench

//  Multi-cycle multiply/divide unit in the EX stage. Consumes operand_1/operand_2 from ID (through ID/EX)
//  for MULT/MULTU/DIV/DIVU and produces the 64-bit {hi, lo} result for the HI/LO registers.

---
 rtl/ex_mul_div_pkg.sv | 27 ++
 rtl/ex_div_step.sv | 28 ++
 rtl/ex_mul_div.sv | 175 +++++++++++++++++
 tb/tb_ex_mul_div.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/ex_mul_div_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit: op codes,
// FSM state encodings and iteration count. The ID-stage decode uses the
// same op codes.
package ex_mul_div_pkg;

    localparam logic [1:0] MULDIV_OP_MULT  = 2'b00;
    localparam logic [1:0] MULDIV_OP_MULTU = 2'b01;
    localparam logic [1:0] MULDIV_OP_DIV   = 2'b10;
    localparam logic [1:0] MULDIV_OP_DIVU  = 2'b11;

    localparam int MD_ITER = 32;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_FIX  = 2'd2
    } md_state_t;

    function automatic logic op_is_div(input logic [1:0] o);
        return (o == MULDIV_OP_DIV) || (o == MULDIV_OP_DIVU);
    endfunction

    function automatic logic op_is_signed(input logic [1:0] o);
        return (o == MULDIV_OP_MULT) || (o == MULDIV_OP_DIV);
    endfunction

endpackage

// File: rtl/ex_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder and subtract the divisor when it fits.
module ex_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH:0] shifted;

    // Trial subtraction; the remainder before shifting is always below the
    // divisor, so the restored result fits back into WIDTH bits.
    always_comb begin
        shifted = {rem, quo[WIDTH-1]};
        if (shifted >= {1'b0, divisor}) begin
            rem_next = shifted[WIDTH-1:0] - divisor;
            quo_next = {quo[WIDTH-2:0], 1'b1};
        end else begin
            rem_next = shifted[WIDTH-1:0];
            quo_next = {quo[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/ex_mul_div.sv
// EX-stage multi-cycle multiply/divide unit producing {hi, lo}.
// Operands are converted to magnitudes on entry; the sign is reapplied in
// FIX. Optional macro MULDIV_FAST_MUL_EN: MULT/MULTU form the product in a
// single combinational multiply (IDLE->FIX) instead of 32 shift-add steps.
module ex_mul_div
    import ex_mul_div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand_1,
    input  logic [WIDTH-1:0] operand_2,
    input  logic             flush,
    output logic             busy,
    output logic             stall_req,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    md_state_t          state;
    logic [4:0]         count;
    logic [1:0]         op_r;
    logic               div0_r;
    logic               neg_1_r;
    logic               neg_2_r;
    logic [WIDTH-1:0]   mag_r;      // multiplicand (MUL) or divisor (DIV)
    logic [2*WIDTH-1:0] acc_r;      // MUL: {upper, multiplier}; DIV: {rem, quo}

    logic               signed_s;
    logic [WIDTH-1:0]   mag_1_s;
    logic [WIDTH-1:0]   mag_2_s;
    logic [WIDTH:0]     add_s;
    logic [2*WIDTH-1:0] mul_next_s;
    logic [WIDTH-1:0]   rem_next_s;
    logic [WIDTH-1:0]   quo_next_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   fix_hi_s;
    logic [WIDTH-1:0]   fix_lo_s;

    assign stall_req = busy | (start & ~flush);

    // Operand magnitudes for signed ops, taken at the start request.
    always_comb begin
        signed_s = op_is_signed(op);
        mag_1_s  = (signed_s && operand_1[WIDTH-1]) ? (-operand_1) : operand_1;
        mag_2_s  = (signed_s && operand_2[WIDTH-1]) ? (-operand_2) : operand_2;
    end

    // One shift-add multiply step: add multiplicand into the upper half when
    // the current multiplier bit is set, then shift the whole accumulator.
    always_comb begin
        add_s      = {1'b0, acc_r[2*WIDTH-1:WIDTH]} +
                     (acc_r[0] ? {1'b0, mag_r} : {(WIDTH+1){1'b0}});
        mul_next_s = {add_s, acc_r[WIDTH-1:1]};
    end

    ex_div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem      (acc_r[2*WIDTH-1:WIDTH]),
        .quo      (acc_r[WIDTH-1:0]),
        .divisor  (mag_r),
        .rem_next (rem_next_s),
        .quo_next (quo_next_s)
    );

    // Unsigned product of the magnitudes, either accumulated or direct.
    always_comb begin
`ifdef MULDIV_FAST_MUL_EN
        prod_s = {{WIDTH{1'b0}}, mag_r} * {{WIDTH{1'b0}}, acc_r[WIDTH-1:0]};
`else
        prod_s = acc_r;
`endif
    end

    // Sign fix: product/quotient negate on differing signs, remainder follows
    // the dividend. Divide-by-zero passes the stored raw values through.
    always_comb begin
        fix_hi_s = acc_r[2*WIDTH-1:WIDTH];
        fix_lo_s = acc_r[WIDTH-1:0];
        if (div0_r) begin
            fix_hi_s = acc_r[2*WIDTH-1:WIDTH];
            fix_lo_s = acc_r[WIDTH-1:0];
        end else if (op_is_div(op_r)) begin
            fix_hi_s = neg_1_r ? (-acc_r[2*WIDTH-1:WIDTH]) : acc_r[2*WIDTH-1:WIDTH];
            fix_lo_s = (neg_1_r ^ neg_2_r) ? (-acc_r[WIDTH-1:0]) : acc_r[WIDTH-1:0];
        end else if (neg_1_r ^ neg_2_r) begin
            {fix_hi_s, fix_lo_s} = -prod_s;
        end else begin
            {fix_hi_s, fix_lo_s} = prod_s;
        end
    end

    // Control FSM with registered busy/done/hi/lo; flush overrides everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= MD_IDLE;
            count   <= 5'd0;
            op_r    <= 2'b00;
            div0_r  <= 1'b0;
            neg_1_r <= 1'b0;
            neg_2_r <= 1'b0;
            mag_r   <= {WIDTH{1'b0}};
            acc_r   <= {(2*WIDTH){1'b0}};
            busy    <= 1'b0;
            done    <= 1'b0;
            hi      <= {WIDTH{1'b0}};
            lo      <= {WIDTH{1'b0}};
        end else if (flush) begin
            state <= MD_IDLE;
            count <= 5'd0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                MD_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        op_r    <= op;
                        neg_1_r <= signed_s & operand_1[WIDTH-1];
                        neg_2_r <= signed_s & operand_2[WIDTH-1];
                        count   <= 5'd0;
                        busy    <= 1'b1;
                        if (op_is_div(op) && (operand_2 == {WIDTH{1'b0}})) begin
                            div0_r <= 1'b1;
                            acc_r  <= {operand_1, {WIDTH{1'b1}}};
                            state  <= MD_FIX;
                        end else if (op_is_div(op)) begin
                            div0_r <= 1'b0;
                            mag_r  <= mag_2_s;
                            acc_r  <= {{WIDTH{1'b0}}, mag_1_s};
                            state  <= MD_CALC;
                        end else begin
                            div0_r <= 1'b0;
                            mag_r  <= mag_1_s;
                            acc_r  <= {{WIDTH{1'b0}}, mag_2_s};
`ifdef MULDIV_FAST_MUL_EN
                            state  <= MD_FIX;
`else
                            state  <= MD_CALC;
`endif
                        end
                    end else begin
                        state <= MD_IDLE;
                    end
                end
                MD_CALC: begin
                    done  <= 1'b0;
                    acc_r <= op_is_div(op_r) ? {rem_next_s, quo_next_s} : mul_next_s;
                    count <= count + 5'd1;
                    if (count == 5'(MD_ITER - 1)) begin
                        state <= MD_FIX;
                    end else begin
                        state <= MD_CALC;
                    end
                end
                MD_FIX: begin
                    hi    <= fix_hi_s;
                    lo    <= fix_lo_s;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= MD_IDLE;
                end
                default: begin
                    state <= MD_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_mul_div.sv
// Directed self-checking bench for ex_mul_div with hand-computed results.
module tb_ex_mul_div;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] operand_1;
    logic [31:0] operand_2;
    logic        flush;
    logic        busy;
    logic        stall_req;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int tests_run    = 0;
    int tests_failed = 0;
    int stall_low    = 0;
    int edges;
    int seen;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_EDGES = 2;
`else
    localparam int MUL_EDGES = 34;
`endif

    ex_mul_div #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .operand_1 (operand_1),
        .operand_2 (operand_2),
        .flush     (flush),
        .busy      (busy),
        .stall_req (stall_req),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present a request on a falling edge, hold it through one rising edge (E0).
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        flush     = 1'b0;
        start     = 1'b1;
        op        = o;
        operand_1 = a;
        operand_2 = b;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Edges from E0 (counted as 1) to the first sample with done high; 0 on timeout.
    task automatic wait_done(input int max, output int n);
        n = 0;
        stall_low = 0;
        for (int i = 1; i <= max; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                n = i + 1;
                break;
            end
            if (!stall_req) stall_low++;
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int exp_edges,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int n;
        issue(o, a, b);
        wait_done(100, n);
        check({tag, "_lat"}, n, exp_edges);
        check({tag, "_hi"}, hi, exp_hi);
        check({tag, "_lo"}, lo, exp_lo);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; flush = 1'b0; op = 2'b00;
        operand_1 = 32'd0; operand_2 = 32'd0;
        #12;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_stall", stall_req, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // 1: MULTU full-scale, latency, stall_req coverage, single-cycle done
        @(negedge clk);
        start = 1'b1; op = 2'b01; operand_1 = 32'hFFFF_FFFF; operand_2 = 32'hFFFF_FFFF;
        #1;
        check("t1_stall_start", stall_req, 1'b1);
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(100, edges);
        check("t1_lat", edges, MUL_EDGES);
        check("t1_stall_hold", stall_low, 0);
        check("t1_hi", hi, 32'hFFFF_FFFE);
        check("t1_lo", lo, 32'h0000_0001);
        @(posedge clk);
        #1;
        check("t1_done_pulse", done, 1'b0);

        // 2: signed multiply with mixed signs
        run_op("t2_mult", 2'b00, 32'hFFFF_FFFD, 32'd5, MUL_EDGES, 32'hFFFF_FFFF, 32'hFFFF_FFF1);

        // 3: divides
        run_op("t3_div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, 34, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("t3_divu", 2'b11, 32'd7, 32'd2, 34, 32'd1, 32'd3);
        run_op("t3_div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 34, 32'd0, 32'h8000_0000);

        // 4: divide by zero
        run_op("t4_divu0", 2'b11, 32'd5, 32'd0, 2, 32'd5, 32'hFFFF_FFFF);
        run_op("t4_div0", 2'b10, 32'd5, 32'd0, 2, 32'd5, 32'hFFFF_FFFF);

        // 5: flush mid-CALC, then immediate restart
        issue(2'b10, 32'd100, 32'd7);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (done) seen++;
        end
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        if (done) seen++;
        check("t5_flush_busy", busy, 1'b0);
        check("t5_no_done", seen, 0);
        check("t5_hold_hi", hi, 32'd5);
        check("t5_hold_lo", lo, 32'hFFFF_FFFF);
        run_op("t5_multu", 2'b01, 32'd3, 32'd4, MUL_EDGES, 32'd0, 32'd12);

        // flush wins over a simultaneous start
        @(negedge clk);
        start = 1'b1; flush = 1'b1; op = 2'b11; operand_1 = 32'd9; operand_2 = 32'd2;
        #1;
        check("fs_stall", stall_req, 1'b0);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("fs_busy", busy, 1'b0);
        @(negedge clk);
        flush = 1'b0;
        check("fs_hold_lo", lo, 32'd12);

        // 6: asynchronous reset mid-CALC
        issue(2'b10, 32'd100, 32'd7);
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("t6_rst_busy", busy, 1'b0);
        check("t6_rst_done", done, 1'b0);
        check("t6_rst_hi", hi, 32'd0);
        check("t6_rst_lo", lo, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // start while busy is ignored
        issue(2'b11, 32'd7, 32'd2);
        @(negedge clk);
        start = 1'b1; op = 2'b01; operand_1 = 32'd3; operand_2 = 32'd4;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(100, edges);
        check("t6_ign_lat", edges, 33);
        check("t6_ign_hi", hi, 32'd1);
        check("t6_ign_lo", lo, 32'd3);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done) seen++;
        end
        check("t6_no_second_done", seen, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
